// File: rtl/extmem_pkg.sv
// Shared definitions for the EXTMEM session loader: FSM encoding,
// header field layout and payload geometry.
package extmem_pkg;

  // Session parser states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_PAY   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Target memory selected by the TYPE bit of the header
  localparam logic TYPE_MASK    = 1'b0;
  localparam logic TYPE_PATTERN = 1'b1;

  // Header byte layout, bit 0 being the first bit on the bus (MSB)
  localparam int HDR_ADDR_FIRST = 0;
  localparam int HDR_ADDR_LAST  = 6;
  localparam int HDR_TYPE_BIT   = 7;

  // Payload geometry
  localparam int         PAYLOAD_BYTES = 4;
  localparam logic [1:0] PAY_LAST_IDX  = 2'(PAYLOAD_BYTES - 1);

  // Extract the 7-bit cell address from a header byte
  function automatic logic [6:0] hdr_addr(input logic [0:7] b);
    return b[HDR_ADDR_FIRST:HDR_ADDR_LAST];
  endfunction

  // Extract the memory type bit from a header byte
  function automatic logic hdr_type(input logic [0:7] b);
    return b[HDR_TYPE_BIT];
  endfunction

endpackage

// File: rtl/extmem_loader_toggle_sync.sv
// Brings the SCL-domain byte toggle into the system clock domain and turns
// every level change into a one-cycle strobe. The strobe is held off until
// the chain has flushed after reset, so a high toggle level at release is
// not mistaken for a byte.
module toggle_sync
  import extmem_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic byte_stb
);

  localparam int STAGES     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int ARM_CYCLES = STAGES + 1;
  localparam int AW         = $clog2(ARM_CYCLES + 1);
  localparam logic [AW-1:0] ARM_DONE = AW'(ARM_CYCLES);

  logic [STAGES-1:0] sync_r;
  logic              edge_r;
  logic [AW-1:0]     arm_cnt_r;
  logic              armed_s;

  assign armed_s  = (arm_cnt_r == ARM_DONE);
  assign byte_stb = armed_s & (sync_r[STAGES-1] ^ edge_r);

  // Synchronizer chain, edge-reference flop and post-reset arm counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= '0;
      edge_r    <= 1'b0;
      arm_cnt_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], tgl};
      edge_r <= sync_r[STAGES-1];
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + AW'(1);
      end else begin
        arm_cnt_r <= arm_cnt_r;
      end
    end
  end

endmodule

// File: rtl/extmem_loader.sv
// Parses one session per parameter from the I2C byte stream:
// header {ADDR,TYPE}, source cell, four payload bytes, then issues a single
// 32-bit write. Trailing bytes are dropped; a stalled session is ended by
// an inter-byte silence timeout.
module extmem_loader
  import extmem_pkg::*;
#(
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [0:7]  EXTMEM,
  input  logic        READ,
  output logic        WE,
  output logic [6:0]  WADDR,
  output logic        WTYPE,
  output logic [7:0]  WSRC,
  output logic [31:0] WDATA,
  output logic        BUSY,
  output logic        ABORT
);

  localparam int GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

  logic          byte_stb_s;
  logic          timeout_s;

  state_t        state_r,   state_nxt;
  logic [GW-1:0] gap_r,     gap_nxt;
  logic [1:0]    idx_r,     idx_nxt;
  logic [23:0]   payload_r, payload_nxt;
  logic          we_r,      we_nxt;
  logic          abort_r,   abort_nxt;
  logic          busy_r,    busy_nxt;
  logic [6:0]    waddr_r,   waddr_nxt;
  logic          wtype_r,   wtype_nxt;
  logic [7:0]    wsrc_r,    wsrc_nxt;
  logic [31:0]   wdata_r,   wdata_nxt;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_toggle_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .tgl      (READ),
    .byte_stb (byte_stb_s)
  );

  // A strobe on the final counter cycle keeps the session alive
  assign timeout_s = (state_r != ST_IDLE) && (gap_r == GAP_MAX) && !byte_stb_s;

  // Next-state, gap counter and output computation
  always_comb begin
    state_nxt   = state_r;
    gap_nxt     = gap_r;
    idx_nxt     = idx_r;
    payload_nxt = payload_r;
    waddr_nxt   = waddr_r;
    wtype_nxt   = wtype_r;
    wsrc_nxt    = wsrc_r;
    wdata_nxt   = wdata_r;
    we_nxt      = 1'b0;
    abort_nxt   = 1'b0;

    if (state_r == ST_IDLE) begin
      gap_nxt = '0;
    end else if (byte_stb_s) begin
      gap_nxt = '0;
    end else if (gap_r == GAP_MAX) begin
      gap_nxt = gap_r;
    end else begin
      gap_nxt = gap_r + GW'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (byte_stb_s) begin
          waddr_nxt = hdr_addr(EXTMEM);
          wtype_nxt = hdr_type(EXTMEM);
          state_nxt = ST_SEL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (byte_stb_s) begin
          wsrc_nxt  = EXTMEM;
          idx_nxt   = 2'd0;
          state_nxt = ST_PAY;
        end else if (timeout_s) begin
          abort_nxt = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SEL;
        end
      end
      ST_PAY: begin
        if (byte_stb_s) begin
          payload_nxt = {payload_r[15:0], EXTMEM};
          if (idx_r == PAY_LAST_IDX) begin
            wdata_nxt = {payload_r, EXTMEM};
            we_nxt    = 1'b1;
            idx_nxt   = 2'd0;
            state_nxt = ST_DRAIN;
          end else begin
            idx_nxt   = idx_r + 2'd1;
          end
        end else if (timeout_s) begin
          abort_nxt   = 1'b1;
          idx_nxt     = 2'd0;
          payload_nxt = 24'd0;
          state_nxt   = ST_IDLE;
        end else begin
          state_nxt = ST_PAY;
        end
      end
      ST_DRAIN: begin
        if (timeout_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        idx_nxt   = 2'd0;
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      gap_r     <= '0;
      idx_r     <= 2'd0;
      payload_r <= 24'd0;
      we_r      <= 1'b0;
      abort_r   <= 1'b0;
      busy_r    <= 1'b0;
      waddr_r   <= 7'd0;
      wtype_r   <= 1'b0;
      wsrc_r    <= 8'd0;
      wdata_r   <= 32'd0;
    end else begin
      state_r   <= state_nxt;
      gap_r     <= gap_nxt;
      idx_r     <= idx_nxt;
      payload_r <= payload_nxt;
      we_r      <= we_nxt;
      abort_r   <= abort_nxt;
      busy_r    <= busy_nxt;
      waddr_r   <= waddr_nxt;
      wtype_r   <= wtype_nxt;
      wsrc_r    <= wsrc_nxt;
      wdata_r   <= wdata_nxt;
    end
  end

  assign WE    = we_r;
  assign ABORT = abort_r;
  assign BUSY  = busy_r;
  assign WADDR = waddr_r;
  assign WTYPE = wtype_r;
  assign WSRC  = wsrc_r;
  assign WDATA = wdata_r;

endmodule

// File: tb/tb_extmem_loader.sv
// Directed bench for extmem_loader with a write/abort scoreboard.
module tb_extmem_loader;
  import extmem_pkg::*;

  localparam int T_OUT = 40;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic        CLK;
  logic        RST_N;
  logic [0:7]  EXTMEM;
  logic        READ;
  logic        WE;
  logic [6:0]  WADDR;
  logic        WTYPE;
  logic [7:0]  WSRC;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        ABORT;

  typedef struct {
    logic [6:0]  addr;
    logic        typ;
    logic [7:0]  src;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr_q[$];
  int  exp_abort_q[$];

  int errors   = 0;
  int checks   = 0;
  int we_seen  = 0;
  int cyc      = 0;
  int last_tog = 0;

  extmem_loader #(
    .TIMEOUT     (T_OUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EXTMEM (EXTMEM),
    .READ   (READ),
    .WE     (WE),
    .WADDR  (WADDR),
    .WTYPE  (WTYPE),
    .WSRC   (WSRC),
    .WDATA  (WDATA),
    .BUSY   (BUSY),
    .ABORT  (ABORT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int spacing);
    @(posedge CLK);
    #1;
    EXTMEM   = b;
    READ     = ~READ;
    last_tog = cyc;
    repeat (spacing - 1) @(posedge CLK);
  endtask

  task automatic send6(input logic [47:0] v, input int spacing);
    for (int i = 0; i < 6; i++) begin
      send(v[47 - 8*i -: 8], spacing);
    end
  endtask

  task automatic expect_wr(input logic [6:0] a, input logic t, input logic [7:0] s,
                           input logic [31:0] d);
    wr_t e;
    e.addr = a; e.typ = t; e.src = s; e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, WE},    32'd0);
    chk({tag, "_waddr"}, {25'd0, WADDR}, 32'd0);
    chk({tag, "_wtype"}, {31'd0, WTYPE}, 32'd0);
    chk({tag, "_wsrc"},  {24'd0, WSRC},  32'd0);
    chk({tag, "_wdata"}, WDATA,          32'd0);
    chk({tag, "_busy"},  {31'd0, BUSY},  32'd0);
    chk({tag, "_abort"}, {31'd0, ABORT}, 32'd0);
  endtask

  // Write monitor: every WE pulse is matched against the next expected write
  always @(negedge CLK) begin
    if (RST_N && WE) begin
      we_seen++;
      if (WE && ABORT) begin
        checks++;
        errors++;
        $display("FAIL we_abort_overlap: both high at cycle %0d", cyc);
      end
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: WE at cycle %0d waddr=0x%0h wdata=0x%0h", cyc, WADDR, WDATA);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        chk("wr_waddr", {25'd0, WADDR}, {25'd0, e.addr});
        chk("wr_wtype", {31'd0, WTYPE}, {31'd0, e.typ});
        chk("wr_wsrc",  {24'd0, WSRC},  {24'd0, e.src});
        chk("wr_wdata", WDATA, e.data);
      end
    end
  end

  // Abort monitor: checks pulse timing and that BUSY is low the cycle after
  always @(negedge CLK) begin
    if (RST_N && ABORT) begin
      if (exp_abort_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_abort: ABORT at cycle %0d", cyc);
      end else begin
        chk("abort_cycle", cyc, exp_abort_q.pop_front());
      end
      @(negedge CLK);
      chk("abort_busy_after", {31'd0, BUSY}, 32'd0);
      chk("abort_width", {31'd0, ABORT}, 32'd0);
    end
  end

  initial begin
    logic busy_bad;
    RST_N  = 1'b0;
    READ   = 1'b0;
    EXTMEM = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);

    // Basic write followed by trailing bytes that must be drained
    expect_wr(7'h2E, TYPE_PATTERN, 8'h03, 32'hDEADBEEF);
    send(8'h5D, 8);
    @(negedge CLK);
    chk("busy_after_header", {31'd0, BUSY}, 32'd1);
    send(8'h03, 8);
    send(8'hDE, 8);
    send(8'hAD, 8);
    send(8'hBE, 8);
    send(8'hEF, 8);
    send(8'h11, 8);
    send(8'h22, 8);
    @(negedge CLK);
    chk("busy_in_drain", {31'd0, BUSY}, 32'd1);
    repeat (T_OUT + 10) @(posedge CLK);
    @(negedge CLK);
    chk("busy_after_drain", {31'd0, BUSY}, 32'd0);
    chk("trail_we_count", we_seen, 32'd1);

    // Fresh session to mask memory
    expect_wr(7'h02, TYPE_MASK, 8'h01, 32'h0000000F);
    send6(48'h04_01_00_00_00_0F, 8);
    repeat (T_OUT + 10) @(posedge CLK);

    // Stall inside PAY: abort exactly T_OUT cycles after the last capture
    send(8'h5D, 8);
    send(8'h03, 8);
    send(8'hDE, 1);
    exp_abort_q.push_back(last_tog + LAT + T_OUT);
    repeat (T_OUT + 10) @(posedge CLK);
    @(negedge CLK);
    chk("abort_busy_idle", {31'd0, BUSY}, 32'd0);
    chk("abort_waddr_kept", {25'd0, WADDR}, 32'h2E);
    chk("abort_wtype_kept", {31'd0, WTYPE}, 32'd1);
    chk("abort_wsrc_kept", {24'd0, WSRC}, 32'h03);
    chk("abort_wdata_held", WDATA, 32'h0000000F);

    // Boundary: each strobe lands on the counter's final cycle
    expect_wr(7'h08, TYPE_MASK, 8'h20, 32'h11223344);
    send(8'h10, T_OUT);
    send(8'h20, T_OUT);
    send(8'h11, T_OUT);
    send(8'h22, 8);
    send(8'h33, 8);
    send(8'h44, 8);
    repeat (T_OUT + 10) @(posedge CLK);

    // Reset in the middle of PAY discards the session
    send(8'h5D, 8);
    send(8'h03, 8);
    send(8'hDE, 8);
    send(8'hAD, 8);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_pay");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    expect_wr(7'h51, TYPE_MASK, 8'h55, 32'h01020304);
    send6(48'hA2_55_01_02_03_04, 8);
    repeat (T_OUT + 10) @(posedge CLK);

    // Release reset with READ held high: no spurious header
    @(negedge CLK);
    RST_N = 1'b0;
    READ  = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    busy_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BUSY !== 1'b0) busy_bad = 1'b1;
    end
    chk("read_high_release_busy", {31'd0, busy_bad}, 32'd0);
    expect_wr(7'h7F, TYPE_PATTERN, 8'h80, 32'hCAFEF00D);
    send6(48'hFF_80_CA_FE_F0_0D, 8);
    repeat (T_OUT + 10) @(posedge CLK);
    @(negedge CLK);

    chk("pending_writes", exp_wr_q.size(), 32'd0);
    chk("pending_aborts", exp_abort_q.size(), 32'd0);
    chk("total_we_count", we_seen, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/extmem_loader.md
Name: extmem_loader

Overview:
- Sits directly downstream of the I2C slave receiver, in the system clock domain.
- Takes the received byte stream (EXTMEM byte plus READ toggle strobe) across from the SCL domain.
- Parses one session per parameter: {ADDR,TYPE} byte, source-cell byte, then four payload bytes.
- Issues a single 32-bit write to the mask or pattern memory; trailing bytes are discarded and stalled sessions are aborted by timeout.

Parameters:
- TIMEOUT, 50000: CLK cycles of inter-byte silence that ends a non-idle session.
- SYNC_STAGES, 2: synchronizer flops on READ (minimum 2).

Ports:
- CLK  in  1  system clock; must be at least 4x SCL.
- RST_N  in  1  asynchronous active-low reset.
- EXTMEM  in  8  [0:7] received byte, bit 0 = first bit on the bus (MSB); stable for a full byte time after each READ toggle.
- READ  in  1  byte strobe from the SCL domain; every level change (either direction) marks one new byte.
- WE  out  1  one-cycle write pulse.
- WADDR  out  7  target cell address, EXTMEM[0:6] of the header byte.
- WTYPE  out  1  EXTMEM[7] of the header byte: 0 = mask, 1 = pattern.
- WSRC  out  8  source-cell byte (second byte of the session).
- WDATA  out  32  payload; first payload byte goes to [31:24], last to [7:0].
- BUSY  out  1  high in any state other than IDLE.
- ABORT  out  1  one-cycle pulse when a session times out before commit.

Behaviour:
- Reset (async assert, sync release): state IDLE; WE=0, WADDR=0, WTYPE=0, WSRC=0, WDATA=0, BUSY=0, ABORT=0; gap counter 0; sync flops 0.
- A reset mid-session discards the session, and no write is issued.
- Strobe generation: READ passes through SYNC_STAGES flops plus one edge flop. BYTE_STB = XOR of the last two flops.
- Strobes are masked for the first SYNC_STAGES+1 cycles after reset release, so that READ=1 at release does not produce a spurious byte.
- Byte capture: EXTMEM is sampled raw on the cycle BYTE_STB is high. Latency from the READ toggle to the sample is SYNC_STAGES+1 CLK.
- FSM:
  - IDLE: on strobe, latch WADDR/WTYPE from the byte and go to SEL.
  - SEL: on strobe, latch WSRC and go to PAY with idx=0.
  - PAY: on strobe, shift the byte into a payload register (MSB first) and increment idx. On the 4th byte (idx==3), copy the payload to WDATA, pulse WE for exactly one cycle on the next clock, and go to DRAIN.
  - DRAIN: strobes are ignored; no further writes this session.
- WADDR/WTYPE/WSRC/WDATA hold their last values when WE is low; they update only on capture or commit. WADDR/WTYPE/WSRC update during capture even if the session later aborts.
- Gap counter: cleared on every strobe and held at 0 in IDLE; otherwise it increments and saturates at TIMEOUT-1.
- Timeout fires when the counter is at TIMEOUT-1 and no strobe arrives that cycle; a strobe in the same cycle wins.
- On timeout:
  - SEL or PAY: go to IDLE, pulse ABORT, no WE, payload index cleared.
  - DRAIN: go to IDLE silently.
- Back-to-back sessions must be separated by at least TIMEOUT idle cycles. Bytes arriving in DRAIN before that are dropped.
- WE and ABORT are never high in the same cycle.
- All outputs are registered.

Decomposition:
- Package extmem_pkg holds:
  - state encoding (IDLE, SEL, PAY, DRAIN);
  - TYPE_MASK=0 and TYPE_PATTERN=1;
  - header field positions (ADDR bits 0..6, TYPE bit 7);
  - PAYLOAD_BYTES=4.
- Sub-module toggle_sync: synchronizer chain, edge detect and post-reset arm mask; outputs BYTE_STB.

Test Plan:
- Basic write: bytes 0x5D, 0x03, 0xDE, 0xAD, 0xBE, 0xEF with gaps below TIMEOUT. Expect one WE pulse with WADDR=0x2E, WTYPE=1, WSRC=0x03, WDATA=0xDEADBEEF, and ABORT=0.
- Trailing bytes: same session plus 0x11, 0x22. Expect exactly one WE. After TIMEOUT idle, BUSY=0. A new session 0x04, 0x01, 0x00, 0x00, 0x00, 0x0F then writes WADDR=0x02, WTYPE=0, WDATA=0x0000000F.
- Abort: send 0x5D, 0x03, 0xDE, then stall TIMEOUT cycles. Expect an ABORT pulse exactly TIMEOUT cycles after the last strobe, no WE, and BUSY low the next cycle.
- Boundary: the next byte's toggle is timed so its strobe lands on the counter's final cycle. Expect no abort, and the session continues.
- Reset during PAY (after 2 payload bytes): all outputs return to reset values. A following full session writes correctly.
- Reset release with READ=1 held, then no toggles for 10 cycles: no strobe and BUSY stays 0. The first toggle afterwards is accepted as a header.
